// File: rtl/classifier_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : classifier_frame_pkg
// Brief    : Shared state encoding and address-width helper for the frame source.
// Revision : 1.0 - initial release
// ============================================================================
package classifier_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Width of an index into a structure of the given depth (never below 1).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_ram.sv
`default_nettype none
// ============================================================================
// Module   : frame_ram
// Brief    : Single-clock pixel store, one write port, one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module frame_ram
    import classifier_frame_pkg::*;
#(
    parameter int DEPTH = 7840,
    parameter int WIDTH = 8,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data_q;

    // Read samples the array before the write lands, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data_q <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data_q;

endmodule
`default_nettype wire

// File: rtl/classifier_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : classifier_frame_source
// Brief    : Feeds stored frames to a classifier and scores its predictions.
// Revision : 1.0 - initial release
// ============================================================================
module classifier_frame_source
    import classifier_frame_pkg::*;
#(
    parameter int PIXEL_W    = 8,
    parameter int DATA_W     = 16,
    parameter int PIXELS     = 784,
    parameter int NUM_FRAMES = 10,
    parameter int LABEL_W    = 4,
    parameter int LOOP_MODE  = 0,
    parameter int READY_MODE = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 load_en,
    input  logic [addr_w(NUM_FRAMES*PIXELS)-1:0] load_addr,
    input  logic [PIXEL_W-1:0]                   load_data,
    input  logic                                 label_we,
    input  logic [addr_w(NUM_FRAMES)-1:0]        label_addr,
    input  logic [LABEL_W-1:0]                   label_data,
    input  logic                                 input_valid_write_en,
    input  logic [7:0]                           input_valid_write_data,
    output logic [7:0]                           input_valid_read_data,
    input  logic [addr_w(PIXELS)-1:0]            input_address_a,
    output logic [DATA_W-1:0]                    input_read_data_a,
    input  logic [LABEL_W-1:0]                   pred_data,
    input  logic                                 pred_valid,
    output logic                                 pred_ready,
    output logic [addr_w(NUM_FRAMES)-1:0]        frame_idx,
    output logic [15:0]                          pred_count,
    output logic [15:0]                          err_count,
    output logic [31:0]                          last_gap,
    output logic                                 done
);

    localparam int c_DEPTH   = NUM_FRAMES * PIXELS;
    localparam int c_MEM_AW  = addr_w(c_DEPTH);
    localparam int c_FRAME_W = addr_w(NUM_FRAMES);
    localparam logic [c_FRAME_W-1:0] c_LAST_FRAME = c_FRAME_W'(NUM_FRAMES - 1);

    state_e               r_state_q, w_state_d;
    logic                 r_valid_q, w_valid_d;
    logic [c_FRAME_W-1:0] r_frame_q, w_frame_d;
    logic [c_FRAME_W-1:0] r_label_ptr_q, w_label_ptr_d;
    logic [15:0]          r_pred_count_q, w_pred_count_d;
    logic [15:0]          r_err_count_q, w_err_count_d;
    logic [31:0]          r_last_gap_q, w_last_gap_d;
    logic [31:0]          r_gap_q, w_gap_d, w_gap_inc;
    logic                 r_rd_zero_q;
    logic [LABEL_W-1:0]   r_label_mem [NUM_FRAMES];

    logic                 w_accept;
    logic                 w_ready_slot;
    logic                 w_rd_in_range;
    logic                 w_ram_we;
    logic [c_MEM_AW-1:0]  w_rd_addr;
    logic [PIXEL_W-1:0]   w_ram_rdata;
    logic                 w_unused_flag_bits;

    assign w_unused_flag_bits = ^input_valid_write_data[7:1];

    // ------------------------------------------------------------------
    // Pixel store and classifier read path
    // ------------------------------------------------------------------
    assign w_ram_we      = load_en && (32'(load_addr) < 32'(c_DEPTH));
    assign w_rd_in_range = 32'(input_address_a) < 32'(PIXELS);

    always_comb begin
        w_rd_addr = '0;
        if (w_rd_in_range) begin
            w_rd_addr = c_MEM_AW'(32'(r_frame_q) * 32'(PIXELS) + 32'(input_address_a));
        end
    end

    frame_ram #(
        .DEPTH (c_DEPTH),
        .WIDTH (PIXEL_W),
        .AW    (c_MEM_AW)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (w_ram_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_ram_rdata)
    );

    // The RAM output register has no reset; a registered flag masks it instead.
    assign input_read_data_a = r_rd_zero_q ? '0 : DATA_W'(w_ram_rdata);

    always_ff @(posedge clk) begin
        if (label_we && (32'(label_addr) < 32'(NUM_FRAMES))) begin
            r_label_mem[label_addr] <= label_data;
        end
    end

    // ------------------------------------------------------------------
    // Prediction handshake pacing
    // ------------------------------------------------------------------
    generate
        if (READY_MODE != 0) begin : g_ready_alt
            logic r_phase_q, w_phase_d;
            always_comb w_phase_d = ~r_phase_q;
            always_ff @(posedge clk) begin
                if (reset) r_phase_q <= 1'b0;
                else       r_phase_q <= w_phase_d;
            end
            assign w_ready_slot = r_phase_q;
        end else begin : g_ready_const
            assign w_ready_slot = 1'b1;
        end
    endgenerate

    assign pred_ready = w_ready_slot && ((r_state_q == ST_FEED) || (r_state_q == ST_DRAIN));
    assign w_accept   = pred_valid && pred_ready;

    // ------------------------------------------------------------------
    // Frame sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_valid_d = r_valid_q;
        w_frame_d = r_frame_q;
        case (r_state_q)
            ST_IDLE: begin
                if (enable) w_state_d = ST_FEED;
            end
            ST_FEED: begin
                if (input_valid_write_en) begin
                    if (r_frame_q != c_LAST_FRAME) begin
                        w_frame_d = r_frame_q + c_FRAME_W'(1);
                        w_valid_d = input_valid_write_data[0];
                    end else if (LOOP_MODE != 0) begin
                        w_frame_d = '0;
                        w_valid_d = input_valid_write_data[0];
                    end else begin
                        w_valid_d = 1'b0;
                        w_state_d = ST_DRAIN;
                    end
                end else if (!r_valid_q) begin
                    w_valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_pred_count_q >= 16'(NUM_FRAMES)) w_state_d = ST_DONE;
            end
            default: begin
                w_state_d = r_state_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoring: counts, label compare and inter-acceptance gap
    // ------------------------------------------------------------------
    always_comb begin
        w_pred_count_d = r_pred_count_q;
        w_err_count_d  = r_err_count_q;
        w_last_gap_d   = r_last_gap_q;
        w_label_ptr_d  = r_label_ptr_q;
        w_gap_inc      = (r_gap_q == '1) ? r_gap_q : r_gap_q + 32'd1;
        w_gap_d        = w_gap_inc;
        if (w_accept) begin
            w_gap_d      = '0;
            w_last_gap_d = w_gap_inc;
            // The label pointer tracks pred_count mod NUM_FRAMES and freezes with it.
            if (r_pred_count_q != '1) begin
                w_pred_count_d = r_pred_count_q + 16'd1;
                w_label_ptr_d  = (r_label_ptr_q == c_LAST_FRAME) ? '0
                                                                 : r_label_ptr_q + c_FRAME_W'(1);
            end
            if ((pred_data != r_label_mem[r_label_ptr_q]) && (r_err_count_q != '1)) begin
                w_err_count_d = r_err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_valid_q      <= 1'b0;
            r_frame_q      <= '0;
            r_label_ptr_q  <= '0;
            r_pred_count_q <= '0;
            r_err_count_q  <= '0;
            r_last_gap_q   <= '0;
            r_gap_q        <= '0;
            r_rd_zero_q    <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_valid_q      <= w_valid_d;
            r_frame_q      <= w_frame_d;
            r_label_ptr_q  <= w_label_ptr_d;
            r_pred_count_q <= w_pred_count_d;
            r_err_count_q  <= w_err_count_d;
            r_last_gap_q   <= w_last_gap_d;
            r_gap_q        <= w_gap_d;
            r_rd_zero_q    <= !w_rd_in_range;
        end
    end

    assign input_valid_read_data = {7'b0, r_valid_q};
    assign frame_idx             = r_frame_q;
    assign pred_count            = r_pred_count_q;
    assign err_count             = r_err_count_q;
    assign last_gap              = r_last_gap_q;
    assign done                  = (r_state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_classifier_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_classifier_frame_source
// Brief    : Three instances (plain, looping, paced-ready) against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_classifier_frame_source;

    localparam int PIX   = 784;
    localparam int NF    = 10;
    localparam int DEPTH = PIX * NF;

    logic        clk = 1'b0;
    logic        reset, enable, load_en, label_we, flag_we, pred_valid;
    logic [12:0] load_addr;
    logic [7:0]  load_data, flag_wdata;
    logic [3:0]  label_addr, label_data, pred_data;
    logic [9:0]  rd_addr;

    logic [7:0]  o_flag  [3];
    logic [15:0] o_rdata [3];
    logic        o_ready [3];
    logic [3:0]  o_frame [3];
    logic [15:0] o_pc    [3];
    logic [15:0] o_ec    [3];
    logic [31:0] o_gap   [3];
    logic        o_done  [3];

    always #5 clk = ~clk;

    classifier_frame_source #(.LOOP_MODE(0), .READY_MODE(0)) u_dut_plain (
        .clk(clk), .reset(reset), .enable(enable),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .label_we(label_we), .label_addr(label_addr), .label_data(label_data),
        .input_valid_write_en(flag_we), .input_valid_write_data(flag_wdata),
        .input_valid_read_data(o_flag[0]),
        .input_address_a(rd_addr), .input_read_data_a(o_rdata[0]),
        .pred_data(pred_data), .pred_valid(pred_valid), .pred_ready(o_ready[0]),
        .frame_idx(o_frame[0]), .pred_count(o_pc[0]), .err_count(o_ec[0]),
        .last_gap(o_gap[0]), .done(o_done[0])
    );

    classifier_frame_source #(.LOOP_MODE(1), .READY_MODE(0)) u_dut_loop (
        .clk(clk), .reset(reset), .enable(enable),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .label_we(label_we), .label_addr(label_addr), .label_data(label_data),
        .input_valid_write_en(flag_we), .input_valid_write_data(flag_wdata),
        .input_valid_read_data(o_flag[1]),
        .input_address_a(rd_addr), .input_read_data_a(o_rdata[1]),
        .pred_data(pred_data), .pred_valid(pred_valid), .pred_ready(o_ready[1]),
        .frame_idx(o_frame[1]), .pred_count(o_pc[1]), .err_count(o_ec[1]),
        .last_gap(o_gap[1]), .done(o_done[1])
    );

    classifier_frame_source #(.LOOP_MODE(0), .READY_MODE(1)) u_dut_rdy (
        .clk(clk), .reset(reset), .enable(enable),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .label_we(label_we), .label_addr(label_addr), .label_data(label_data),
        .input_valid_write_en(flag_we), .input_valid_write_data(flag_wdata),
        .input_valid_read_data(o_flag[2]),
        .input_address_a(rd_addr), .input_read_data_a(o_rdata[2]),
        .pred_data(pred_data), .pred_valid(pred_valid), .pred_ready(o_ready[2]),
        .frame_idx(o_frame[2]), .pred_count(o_pc[2]), .err_count(o_ec[2]),
        .last_gap(o_gap[2]), .done(o_done[2])
    );

    // Reference model: instance 1 loops frames, instance 2 paces ready on odd cycles.
    bit [7:0]        mem [DEPTH];
    int unsigned     lbl [NF];
    bit              m_started [3], m_drain [3], m_done [3], m_valid [3];
    int unsigned     m_frame [3], m_pc [3], m_ec [3], m_cyc [3], m_rdata [3];
    longint unsigned m_gap [3], m_last_gap [3];
    int              checks = 0;
    int              errors = 0;

    function automatic bit model_ready(input int k);
        return m_started[k] && !m_done[k] && ((k != 2) || (m_cyc[k] % 2 == 1));
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit acc;
            if (reset) begin
                m_started[k] = 0; m_drain[k] = 0; m_done[k] = 0; m_valid[k] = 0;
                m_frame[k] = 0; m_pc[k] = 0; m_ec[k] = 0; m_cyc[k] = 0; m_rdata[k] = 0;
                m_gap[k] = 0; m_last_gap[k] = 0;
            end else begin
                acc = pred_valid && model_ready(k);
                m_rdata[k] = (rd_addr < PIX) ? 32'(mem[m_frame[k] * PIX + rd_addr]) : 0;
                if (!m_started[k]) begin
                    if (enable) m_started[k] = 1;
                end else if (!m_drain[k]) begin
                    if (flag_we) begin
                        if ((m_frame[k] < NF - 1) || (k == 1)) begin
                            m_frame[k] = (m_frame[k] + 1) % NF;
                            m_valid[k] = flag_wdata[0];
                        end else begin
                            m_valid[k] = 0;
                            m_drain[k] = 1;
                        end
                    end else if (!m_valid[k]) begin
                        m_valid[k] = 1;
                    end
                end else if (!m_done[k] && (m_pc[k] >= NF)) begin
                    m_done[k] = 1;
                end
                if (acc) begin
                    if ((pred_data != lbl[m_pc[k] % NF]) && (m_ec[k] < 65535)) m_ec[k]++;
                    if (m_pc[k] < 65535) m_pc[k]++;
                    m_last_gap[k] = (m_gap[k] + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_gap[k] + 1;
                    m_gap[k] = 0;
                end else begin
                    m_gap[k] = (m_gap[k] + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_gap[k] + 1;
                end
                m_cyc[k]++;
            end
        end
        if (load_en && (load_addr < DEPTH)) mem[load_addr] = load_data;
        if (label_we && (label_addr < NF)) lbl[label_addr] = label_data;
    endtask

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("frame_idx", k, 64'(o_frame[k]), 64'(m_frame[k]));
            chk("pred_count", k, 64'(o_pc[k]), 64'(m_pc[k]));
            chk("err_count", k, 64'(o_ec[k]), 64'(m_ec[k]));
            chk("last_gap", k, 64'(o_gap[k]), m_last_gap[k]);
            chk("done", k, 64'(o_done[k]), 64'(m_done[k]));
            chk("pred_ready", k, 64'(o_ready[k]), 64'(model_ready(k)));
            chk("valid_rd", k, 64'(o_flag[k]), 64'(m_valid[k]));
            chk("read_data", k, 64'(o_rdata[k]), 64'(m_rdata[k]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1; enable = 0; load_en = 0; load_addr = '0; load_data = '0;
        label_we = 0; label_addr = '0; label_data = '0; flag_we = 0; flag_wdata = '0;
        rd_addr = '0; pred_data = '0; pred_valid = 0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk("reset_frame", k, 64'(o_frame[k]), 64'd0);
            chk("reset_done", k, 64'(o_done[k]), 64'd0);
            chk("reset_ready", k, 64'(o_ready[k]), 64'd0);
        end
        reset = 0;

        // Full load with reads parked out of range; labels 0..9 alongside.
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_addr = 13'(i);
            load_data = (i == PIX + 5) ? 8'hAB : 8'($urandom);
            label_we = (i < NF); label_addr = 4'(i); label_data = 4'(i);
            rd_addr = 10'($urandom_range(PIX, 1023));
            tick();
        end
        label_we = 0;

        // Rewrite frame 0 while reading the same address half the time.
        for (int i = 0; i < PIX; i++) begin
            load_addr = 13'(i); load_data = 8'($urandom);
            rd_addr = ($urandom_range(0, 1) == 1) ? 10'(i) : 10'($urandom_range(0, 1023));
            tick();
        end
        load_en = 0;

        enable = 1;
        tick();
        for (int f = 0; f < 12; f++) begin
            if (f == 1) begin
                rd_addr = 10'd5;
                tick();
                chk("frame1_addr5", 0, 64'(o_rdata[0]), 64'h00AB);
            end
            repeat ($urandom_range(1, 3)) begin
                rd_addr = 10'($urandom_range(0, 1023));
                tick();
            end
            flag_we = 1; flag_wdata = (f < NF) ? 8'h00 : 8'($urandom);
            tick();
            flag_we = 0;
            chk("feed_step", 0, 64'(o_frame[0]), 64'((f + 1 < NF - 1) ? f + 1 : NF - 1));
            if (f == NF - 1) chk("drain_valid", 0, 64'(o_flag[0]), 64'd0);
        end
        chk("loop_frame", 1, 64'(o_frame[1]), 64'd2);
        chk("loop_done", 1, 64'(o_done[1]), 64'd0);
        chk("loop_ready", 1, 64'(o_ready[1]), 64'd1);

        // Four-cycle held burst; a flag write coincides with the first prediction.
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1; pred_data = (i == 3) ? 4'd7 : 4'(i);
            flag_we = (i == 0); flag_wdata = 8'h01;
            rd_addr = 10'($urandom_range(0, 1023));
            tick();
        end
        flag_we = 0; pred_valid = 0;
        chk("rdy_accepts", 2, 64'(o_pc[2]), 64'd2);
        chk("rdy_gap", 2, 64'(o_gap[2]), 64'd2);
        chk("burst_accepts", 0, 64'(o_pc[0]), 64'd4);

        for (int p = 4; p < NF; p++) begin
            repeat ($urandom_range(0, 2)) begin
                pred_valid = 0; rd_addr = 10'($urandom_range(0, 1023));
                tick();
            end
            pred_valid = 1; pred_data = 4'(p);
            tick();
        end
        pred_valid = 0;
        repeat (3) tick();
        chk("final_pred_count", 0, 64'(o_pc[0]), 64'd10);
        chk("final_err_count", 0, 64'(o_ec[0]), 64'd1);
        chk("final_done", 0, 64'(o_done[0]), 64'd1);
        chk("done_ready", 0, 64'(o_ready[0]), 64'd0);
        for (int i = 0; i < 6; i++) begin
            pred_valid = 1'($urandom_range(0, 1)); pred_data = 4'($urandom);
            tick();
        end
        pred_valid = 0;
        chk("done_holds_count", 0, 64'(o_pc[0]), 64'd10);

        // Restart, advance to frame 4, then reset mid-operation.
        reset = 1; tick(); reset = 0;
        tick();
        for (int f = 0; f < 4; f++) begin
            tick();
            flag_we = 1; flag_wdata = 8'h00;
            tick();
            flag_we = 0;
        end
        pred_valid = 1; pred_data = 4'd0;
        rd_addr = 10'($urandom_range(0, PIX - 1));
        repeat (2) tick();
        chk("pre_reset_frame", 0, 64'(o_frame[0]), 64'd4);
        reset = 1; tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_frame", k, 64'(o_frame[k]), 64'd0);
            chk("rst_pred_count", k, 64'(o_pc[k]), 64'd0);
            chk("rst_err_count", k, 64'(o_ec[k]), 64'd0);
            chk("rst_last_gap", k, 64'(o_gap[k]), 64'd0);
            chk("rst_done", k, 64'(o_done[k]), 64'd0);
            chk("rst_valid", k, 64'(o_flag[k]), 64'd0);
            chk("rst_rdata", k, 64'(o_rdata[k]), 64'd0);
        end
        reset = 0; pred_valid = 0;
        repeat (2) tick();
        for (int a = 0; a < 8; a++) begin
            rd_addr = 10'($urandom_range(0, PIX - 1));
            tick();
            chk("frame0_retained", 0, 64'(o_rdata[0]), 64'(mem[rd_addr]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/classifier_frame_source.md
CLASSIFIER_FRAME_SOURCE -- requirements
Module: classifier_frame_source

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8, meaning the stored pixel width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the read-data width presented to the classifier (>= PIXEL_W).
REQ-003 SHALL have parameter PIXELS, default 784, meaning the number of pixels per frame.
REQ-004 SHALL have parameter NUM_FRAMES, default 10, meaning the number of frame slots.
REQ-005 SHALL have parameter LABEL_W, default 4, meaning the prediction and label width.
REQ-006 SHALL have parameter LOOP_MODE, default 0, meaning frames wrap to slot 0 after the last one when set to 1.
REQ-007 SHALL have parameter READY_MODE, default 0, meaning pred_ready is always 1 when 0 and alternates 1/0 every cycle when 1.
REQ-008 SHALL have ports clk (in, 1, clock) and reset (in, 1); the design uses one clock, and reset is synchronous and active-high.
REQ-009 SHALL have port enable (in, 1), a level signal that allows feeding.
REQ-010 SHALL have ports load_en (in, 1), load_addr (in, clog2(NUM_FRAMES*PIXELS)) and load_data (in, PIXEL_W), forming the pixel memory write port.
REQ-011 SHALL have ports label_we (in, 1), label_addr (in, clog2(NUM_FRAMES)) and label_data (in, LABEL_W), forming the expected-label write port.
REQ-012 SHALL have ports input_valid_write_en (in, 1), input_valid_write_data (in, 8) and input_valid_read_data (out, 8), forming the classifier valid-flag register.
REQ-013 SHALL have ports input_address_a (in, clog2(PIXELS)) and input_read_data_a (out, DATA_W), forming the classifier pixel read port.
REQ-014 SHALL have ports pred_data (in, LABEL_W), pred_valid (in, 1) and pred_ready (out, 1), forming the prediction stream sink.
REQ-015 SHALL have status outputs frame_idx (out, clog2(NUM_FRAMES)), pred_count (out, 16), err_count (out, 16), last_gap (out, 32) and done (out, 1).

Function
REQ-016 SHALL implement states IDLE, FEED, DRAIN and DONE.
REQ-017 SHALL transition IDLE->FEED when enable=1, FEED->DRAIN on a flag write that retires the last frame with LOOP_MODE=0, DRAIN->DONE when pred_count reaches NUM_FRAMES, and stay in DONE until reset.
REQ-018 SHALL drive input_valid_read_data as {7'b0, valid}.
REQ-019 SHALL set valid to 1 in the cycle after the cycle in which it is observed 0 in FEED.
REQ-020 SHALL, on input_valid_write_en in FEED, set valid <= input_valid_write_data[0] and advance frame_idx by 1.
REQ-021 SHALL, when the last frame is retired (frame_idx = NUM_FRAMES-1 plus a write): wrap frame_idx to 0 if LOOP_MODE=1; otherwise force valid to 0, hold frame_idx, and enter DRAIN.
REQ-022 SHALL ignore flag writes outside FEED.
REQ-023 SHALL register input_read_data_a with 1-cycle latency as the zero-extended mem[frame_idx*PIXELS + input_address_a], using the frame_idx value in the address cycle.
REQ-024 SHALL return 0 on input_read_data_a for an address >= PIXELS.
REQ-025 SHALL give load_en to the same address priority over a classifier read; that read returns the old data.
REQ-026 SHALL accept a prediction on pred_valid & pred_ready.
REQ-027 SHALL, on acceptance, increment pred_count (saturating at 0xFFFF).
REQ-028 SHALL, on acceptance, compare pred_data against label[pred_count mod NUM_FRAMES] and increment err_count (saturating) on mismatch.
REQ-029 SHALL, on acceptance, load last_gap with the cycles since the previous acceptance (or since reset for the first); the gap counter saturates at 2^32-1.
REQ-030 SHALL hold pred_ready at 0 in IDLE and DONE.
REQ-031 SHALL assert done only in DONE.
REQ-032 SHALL treat a simultaneous flag write and prediction acceptance as independent events, both taking effect.

Reset
REQ-033 SHALL, on reset, clear state to IDLE, and valid, frame_idx, pred_count, err_count, last_gap, the gap counter, input_read_data_a and done to 0.
REQ-034 SHALL set pred_ready to 0 on reset.
REQ-035 SHALL apply reset mid-operation on the next clock edge and retain pixel and label memory contents.

Structure
REQ-036 SHALL place the state enum and the ADDR width helper in package classifier_frame_pkg.
REQ-037 SHALL use one sub-module, frame_ram: single-clock, one write port and one registered read port, sized NUM_FRAMES*PIXELS x PIXEL_W.

Verification
REQ-038 SHALL cover: 10 frames loaded, enable=1, DUT writes 0 once per frame -> frame_idx steps 0..9, then DRAIN, valid=0.
REQ-039 SHALL cover: pixel mem[784+5]=0xAB, frame_idx=1, address 5 -> input_read_data_a=0x00AB one cycle later.
REQ-040 SHALL cover: labels 0..9 and predictions 0..9 with pred 3 replaced by 7 -> pred_count=10, err_count=1, done=1.
REQ-041 SHALL cover: LOOP_MODE=1 with 12 flag writes -> frame_idx=2, state stays FEED, done=0.
REQ-042 SHALL cover: READY_MODE=1 with pred_valid held for 4 cycles -> exactly 2 acceptances, and last_gap=2 on the second.
REQ-043 SHALL cover: reset asserted at frame 4 -> all status outputs 0 next cycle; re-enable -> frame 0 pixels still intact.
